// File: rtl/adsr_envelope_if.sv
// adsr_envelope_if: control, data and status bundle of the ADSR envelope stage.
//   master : the voice controller / ROM side. It drives sample_tick, gate, the rates,
//            sustain_level and sample_in, and it observes the envelope outputs.
//   slave  : the envelope stage itself. It consumes the inputs and drives sample_out,
//            out_valid, env_level, env_state and busy.
interface adsr_envelope_if #(
  parameter int unsigned DATA_BITS = 12,
  parameter int unsigned ENV_BITS  = 16
);
  logic                 sample_tick;
  logic                 gate;
  logic [ENV_BITS-1:0]  attack_rate;
  logic [ENV_BITS-1:0]  decay_rate;
  logic [ENV_BITS-1:0]  sustain_level;
  logic [ENV_BITS-1:0]  release_rate;
  logic [DATA_BITS-1:0] sample_in;
  logic [DATA_BITS-1:0] sample_out;
  logic                 out_valid;
  logic [ENV_BITS-1:0]  env_level;
  logic [2:0]           env_state;
  logic                 busy;

  modport master (
    output sample_tick, gate, attack_rate, decay_rate, sustain_level, release_rate, sample_in,
    input  sample_out, out_valid, env_level, env_state, busy
  );

  modport slave (
    input  sample_tick, gate, attack_rate, decay_rate, sustain_level, release_rate, sample_in,
    output sample_out, out_valid, env_level, env_state, busy
  );
endinterface

// File: rtl/adsr_envelope.sv
// adsr_envelope: attack/decay/sustain/release amplitude envelope for one voice.
// The stage scales offset-binary ROM samples by the current envelope level and
// returns them in the same offset-binary format.
//
// Ports:
//   clk : system clock
//   rst : asynchronous, active-high reset
//   bus : adsr_envelope_if.slave. Its inputs are sample_tick, gate, attack_rate, decay_rate,
//         sustain_level, release_rate and sample_in. Its outputs are sample_out, out_valid,
//         env_level, env_state (IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4) and busy.
//
// Configuration macro:
//   ADSR_EXP_RELEASE_EN : when defined, each RELEASE step subtracts
//                         (env >> release_rate[3:0]) + 1, which gives an exponential release.
//                         When undefined, each step subtracts release_rate, which gives a
//                         linear release.
//
// Timing: a sample tick that arrives in cycle t updates env and state in t+1. The scaled
// sample for that tick uses the envelope value from before the update. It appears in
// t+2 together with a one-cycle out_valid pulse.
module adsr_envelope #(
  parameter int unsigned DATA_BITS = 12,
  parameter int unsigned ENV_BITS  = 16
) (
  input logic            clk,
  input logic            rst,
  adsr_envelope_if.slave bus
);

  localparam int unsigned ProdBits = DATA_BITS + ENV_BITS + 1;
  localparam logic [ENV_BITS-1:0]  EnvMax = '1;
  localparam logic [DATA_BITS-1:0] Mid    = {1'b1, {(DATA_BITS-1){1'b0}}};
  localparam logic [ENV_BITS:0]    One    = (ENV_BITS+1)'(1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAttack  = 3'd1,
    StDecay   = 3'd2,
    StSustain = 3'd3,
    StRelease = 3'd4
  } state_e;

  state_e              state_q;
  logic [ENV_BITS-1:0] env_q;
  logic                gate_prev_q;

  // Pipeline registers
  logic                        s1_valid_q;
  logic signed [DATA_BITS-1:0] c_q;
  logic [ENV_BITS-1:0]         env_s1_q;
  logic                        out_valid_q;
  logic [DATA_BITS-1:0]        sample_out_q;

  // Candidate next envelope values. They are one or two bits wider so that overflow
  // and underflow can be tested directly.
  logic [ENV_BITS:0]          attack_sum;
  logic signed [ENV_BITS+1:0] decay_diff;
  logic [ENV_BITS:0]          rel_step;
  logic                       rise;
  logic                       held_state;

  assign attack_sum = {1'b0, env_q} + {1'b0, bus.attack_rate};
  assign decay_diff = $signed({2'b00, env_q}) - $signed({2'b00, bus.decay_rate});

`ifdef ADSR_EXP_RELEASE_EN
  logic unused_rel_hi;
  assign unused_rel_hi = ^bus.release_rate[ENV_BITS-1:4];
  assign rel_step = {1'b0, env_q >> bus.release_rate[3:0]} + One;
`else
  assign rel_step = {1'b0, bus.release_rate};
`endif

  assign rise       = bus.gate && !gate_prev_q;
  assign held_state = (state_q == StAttack) || (state_q == StDecay) || (state_q == StSustain);

  // Envelope FSM. It advances only on sample ticks. A gate event uses up its tick
  // without moving env, and a retrigger continues from the current env.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      env_q       <= '0;
      gate_prev_q <= 1'b0;
    end else if (bus.sample_tick) begin
      gate_prev_q <= bus.gate;
      if (rise) begin
        state_q <= StAttack;
      end else if (!bus.gate && held_state) begin
        state_q <= StRelease;
      end else begin
        case (state_q)
          StIdle: env_q <= '0;
          StAttack: begin
            if (attack_sum >= {1'b0, EnvMax}) begin
              env_q   <= EnvMax;
              state_q <= StDecay;
            end else begin
              env_q <= attack_sum[ENV_BITS-1:0];
            end
          end
          StDecay: begin
            if (decay_diff <= $signed({2'b00, bus.sustain_level})) begin
              env_q   <= bus.sustain_level;
              state_q <= StSustain;
            end else begin
              env_q <= decay_diff[ENV_BITS-1:0];
            end
          end
          // Follows live changes to sustain_level
          StSustain: env_q <= bus.sustain_level;
          StRelease: begin
            if (rel_step >= {1'b0, env_q}) begin
              env_q   <= '0;
              state_q <= StIdle;
            end else begin
              env_q <= env_q - rel_step[ENV_BITS-1:0];
            end
          end
          default: begin
            env_q   <= '0;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  // Stage 2 multiply. The signed sample times the zero-extended envelope always fits in
  // ProdBits. After the arithmetic shift the result lies in the signed DATA_BITS range.
  logic signed [ProdBits-1:0] c_ext;
  logic signed [ProdBits-1:0] env_ext;
  logic signed [ProdBits-1:0] prod;
  logic [DATA_BITS-1:0]       scaled;

  assign c_ext   = ProdBits'(c_q);
  assign env_ext = ProdBits'({1'b0, env_s1_q});
  assign prod    = c_ext * env_ext;
  assign scaled  = DATA_BITS'(prod >>> ENV_BITS);

  // The pipeline valid bits advance every cycle, so back-to-back ticks stream out with
  // no gaps. Stage 1 data is captured only on a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      c_q          <= '0;
      env_s1_q     <= '0;
      out_valid_q  <= 1'b0;
      sample_out_q <= Mid;
    end else begin
      s1_valid_q  <= bus.sample_tick;
      out_valid_q <= s1_valid_q;
      if (bus.sample_tick) begin
        // Flipping the MSB converts offset binary to two's complement
        c_q      <= bus.sample_in ^ Mid;
        env_s1_q <= env_q;
      end
      if (s1_valid_q) begin
        sample_out_q <= scaled ^ Mid;
      end
    end
  end

  assign bus.sample_out = sample_out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.env_level  = env_q;
  assign bus.env_state  = state_q;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope. The bench contains three parts:
//   - a table of directed ticks with constant expectations,
//   - hand-written multi-cycle sequences covering release, retrigger, latency and
//     mid-operation reset,
//   - randomized ticks checked against an integer reference model.
// A negedge monitor compares every out_valid sample with the queue of expected outputs.
module tb_adsr_envelope;
  localparam int DB     = 12;
  localparam int EB     = 16;
  localparam int EnvMax = 65535;

  logic clk = 1'b0;
  logic rst = 1'b0;

  adsr_envelope_if #(.DATA_BITS(DB), .ENV_BITS(EB)) bus ();

  adsr_envelope #(.DATA_BITS(DB), .ENV_BITS(EB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_env      = 0;
  int m_state    = 0;
  bit m_gate_prev = 1'b0;
  int exp_q[$];
  bit rnd_gate = 1'b0;

  typedef struct {
    logic        g;
    logic [15:0] ar;
    logic [15:0] dr;
    logic [15:0] sl;
    logic [15:0] rr;
    logic [11:0] s;
    int          env;
    int          st;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Output sample = floor(centred * env / 2^16) + midpoint
  function automatic int scale_ref(input int s, input int env);
    longint c;
    longint p;
    longint q;
    c = longint'(s) - 2048;
    p = c * longint'(env);
    if (p >= 0) q = p / 65536;
    else q = -((-p + 65535) / 65536);
    return int'(q + 2048);
  endfunction

  task automatic model_tick(input bit g, input int s);
    int ar;
    int dr;
    int sl;
    int rr;
    int step;
    ar = int'(bus.attack_rate);
    dr = int'(bus.decay_rate);
    sl = int'(bus.sustain_level);
    rr = int'(bus.release_rate);
    exp_q.push_back(scale_ref(s, m_env));
    if (g && !m_gate_prev) begin
      m_state = 1;
    end else if (!g && m_state >= 1 && m_state <= 3) begin
      m_state = 4;
    end else begin
      case (m_state)
        0: m_env = 0;
        1: begin
          if (m_env + ar >= EnvMax) begin
            m_env = EnvMax;
            m_state = 2;
          end else begin
            m_env = m_env + ar;
          end
        end
        2: begin
          if (m_env - dr <= sl) begin
            m_env = sl;
            m_state = 3;
          end else begin
            m_env = m_env - dr;
          end
        end
        3: m_env = sl;
        default: begin
`ifdef ADSR_EXP_RELEASE_EN
          step = m_env / (1 << (rr % 16)) + 1;
`else
          step = rr;
`endif
          if (m_env - step <= 0) begin
            m_env = 0;
            m_state = 0;
          end else begin
            m_env = m_env - step;
          end
        end
      endcase
    end
    m_gate_prev = g;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  // Drives one tick, steps the model, and checks the state that becomes visible one cycle later
  task automatic do_tick(input bit g, input logic [11:0] s);
    bus.gate        = g;
    bus.sample_in   = s;
    bus.sample_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_tick = 1'b0;
    model_tick(g, int'(s));
    check("model_env", longint'(bus.env_level), longint'(m_env));
    check("model_state", longint'(bus.env_state), longint'(m_state));
    check("model_busy", longint'(bus.busy), longint'(m_state != 0));
  endtask

  task automatic tick_expect(input string name, input bit g, input logic [11:0] s,
                             input int env, input int st);
    do_tick(g, s);
    check({name, "_env"}, longint'(bus.env_level), longint'(env));
    check({name, "_state"}, longint'(bus.env_state), longint'(st));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.sample_tick = 1'b0;
    exp_q.delete();
    m_env = 0;
    m_state = 0;
    m_gate_prev = 1'b0;
    #1;
    check("rst_env", longint'(bus.env_level), 0);
    check("rst_state", longint'(bus.env_state), 0);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_valid", longint'(bus.out_valid), 0);
    check("rst_sample_out", longint'(bus.sample_out), 2048);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic scale_check(input logic [11:0] s, input int exp);
    repeat (3) idle();
    do_tick(1'b1, s);
    check("lat_t1_valid", longint'(bus.out_valid), 0);
    idle();
    check("lat_t2_valid", longint'(bus.out_valid), 1);
    check("lat_sample_out", longint'(bus.sample_out), longint'(exp));
  endtask

  function automatic logic [15:0] rand_rate();
    if ($urandom_range(0, 3) == 0) return 16'($urandom_range(0, 65535));
    return 16'($urandom_range(0, 3000));
  endfunction

  always @(negedge clk) begin
    int e;
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL out_valid_unexpected: got 1 expected 0");
      end else begin
        e = exp_q.pop_front();
        check("sample_out", longint'(bus.sample_out), longint'(e));
      end
    end
  end

  initial begin
    bus.sample_tick   = 1'b0;
    bus.gate          = 1'b0;
    bus.attack_rate   = 16'd16384;
    bus.decay_rate    = 16'd8192;
    bus.sustain_level = 16'd40000;
    bus.release_rate  = 16'd10000;
    bus.sample_in     = 12'd0;
    #2;
    do_reset();

    // Idle ticks with gate low: env stays 0, so every output sits at the midpoint
    for (int i = 0; i < 4; i++) begin
      tick_expect("idle", 1'b0, 12'd4095, 0, 0);
      if (i == 1) check("b2b_valid", longint'(bus.out_valid), 1);
    end
    repeat (3) idle();

    vecs.push_back('{1'b1, 16'd16384, 16'd8192, 16'd40000, 16'd10000, 12'd4095, 0, 1});
    vecs.push_back('{1'b1, 16'd16384, 16'd8192, 16'd40000, 16'd10000, 12'd1000, 16384, 1});
    vecs.push_back('{1'b1, 16'd16384, 16'd8192, 16'd40000, 16'd10000, 12'd3000, 32768, 1});
    vecs.push_back('{1'b1, 16'd16384, 16'd8192, 16'd40000, 16'd10000, 12'd2048, 49152, 1});
    vecs.push_back('{1'b1, 16'd16384, 16'd8192, 16'd40000, 16'd10000, 12'd0, 65535, 2});
    vecs.push_back('{1'b1, 16'd16384, 16'd8192, 16'd40000, 16'd10000, 12'd4095, 57343, 2});
    vecs.push_back('{1'b1, 16'd16384, 16'd8192, 16'd40000, 16'd10000, 12'd4095, 49151, 2});
    vecs.push_back('{1'b1, 16'd16384, 16'd8192, 16'd40000, 16'd10000, 12'd100, 40959, 2});
    vecs.push_back('{1'b1, 16'd16384, 16'd8192, 16'd40000, 16'd10000, 12'd2500, 40000, 3});
    vecs.push_back('{1'b1, 16'd16384, 16'd8192, 16'd30000, 16'd10000, 12'd3500, 30000, 3});
    vecs.push_back('{1'b1, 16'd16384, 16'd8192, 16'd40000, 16'd10000, 12'd700, 40000, 3});

    foreach (vecs[i]) begin
      bus.attack_rate   = vecs[i].ar;
      bus.decay_rate    = vecs[i].dr;
      bus.sustain_level = vecs[i].sl;
      bus.release_rate  = vecs[i].rr;
      tick_expect("vec", vecs[i].g, vecs[i].s, vecs[i].env, vecs[i].st);
    end

`ifdef ADSR_EXP_RELEASE_EN
    bus.release_rate = 16'd1;
    tick_expect("rel_gate", 1'b0, 12'd2048, 40000, 4);
    tick_expect("rel1", 1'b0, 12'd4095, 19999, 4);
    tick_expect("rel2", 1'b0, 12'd0, 9999, 4);
    tick_expect("rel3", 1'b0, 12'd1234, 4999, 4);
    tick_expect("retrig", 1'b1, 12'd2048, 4999, 1);
    tick_expect("retrig_att", 1'b1, 12'd2048, 21383, 1);
`else
    tick_expect("rel_gate", 1'b0, 12'd2048, 40000, 4);
    tick_expect("rel1", 1'b0, 12'd4095, 30000, 4);
    tick_expect("rel2", 1'b0, 12'd0, 20000, 4);
    tick_expect("retrig", 1'b1, 12'd1234, 20000, 1);
    tick_expect("retrig_att", 1'b1, 12'd2048, 36384, 1);
    tick_expect("rel_b0", 1'b0, 12'd2048, 36384, 4);
    tick_expect("rel_b1", 1'b0, 12'd3000, 26384, 4);
    tick_expect("rel_b2", 1'b0, 12'd3000, 16384, 4);
    tick_expect("rel_b3", 1'b0, 12'd3000, 6384, 4);
    tick_expect("rel_end", 1'b0, 12'd3000, 0, 0);
    tick_expect("idle_hold", 1'b0, 12'd3000, 0, 0);
    tick_expect("retrig2", 1'b1, 12'd3000, 0, 1);
    tick_expect("retrig2_att", 1'b1, 12'd3000, 16384, 1);
`endif

    // Reset in the middle of a release while a sample is still in flight
    do_tick(1'b0, 12'd3333);
    do_tick(1'b0, 12'd3333);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      check("post_rst_valid", longint'(bus.out_valid), 0);
    end

    // Full-scale envelope for the scaling and latency checks
    bus.attack_rate   = 16'd65535;
    bus.decay_rate    = 16'd0;
    bus.sustain_level = 16'd65535;
    tick_expect("full_gate", 1'b1, 12'd2048, 0, 1);
    tick_expect("full_att", 1'b1, 12'd2048, 65535, 2);
    tick_expect("full_dec", 1'b1, 12'd2048, 65535, 3);
    scale_check(12'd4095, 4094);
    scale_check(12'd0, 0);
    scale_check(12'd2048, 2048);
    scale_check(12'd3000, 2999);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        bus.attack_rate  = rand_rate();
        bus.decay_rate   = rand_rate();
        bus.release_rate = rand_rate();
      end
      if (i % 37 == 0) bus.sustain_level = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 15) == 0) rnd_gate = !rnd_gate;
      if (i == 1500) do_reset();
      if ($urandom_range(0, 1) == 1) do_tick(rnd_gate, 12'($urandom_range(0, 4095)));
      else idle();
    end

    repeat (4) idle();
    check("drain_pending", longint'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adsr_envelope.md
# adsr_envelope

Amplitude envelope stage directly downstream of the sine ROM in the synthesizer voice path. Consumes the ROM's registered offset-binary sample once per sample tick, runs an attack/decay/sustain/release state machine driven by a note gate, and emits the sample scaled by the current envelope level in the same offset-binary format for the DAC/mixer stage.

## Interface
- DATA_BITS, 12, sample width; matches the ROM output, offset binary, midpoint 2^(DATA_BITS-1)
- ENV_BITS, 16, envelope accumulator width; ENV_MAX = 2^ENV_BITS-1
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- sample_tick  in  1  one-cycle strobe at sample rate; ROM data valid on this cycle
- gate  in  1  note held
- attack_rate  in  ENV_BITS  per-tick increment in ATTACK
- decay_rate  in  ENV_BITS  per-tick decrement in DECAY
- sustain_level  in  ENV_BITS  SUSTAIN hold level
- release_rate  in  ENV_BITS  per-tick decrement in RELEASE
- sample_in  in  DATA_BITS  ROM data
- sample_out  out  DATA_BITS  scaled sample, offset binary
- out_valid  out  1  one-cycle pulse when sample_out updates
- env_level  out  ENV_BITS  current envelope value
- env_state  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
- busy  out  1  env_state != IDLE

## Operation
- All state changes occur only on cycles with sample_tick=1; otherwise everything holds (except pipeline stage 2).
- gate_prev register holds gate as sampled at previous tick.
- Gate events (consume the tick, env unchanged that tick):
  - gate=1, gate_prev=0, any state -> ATTACK (retrigger from current env, no reset to 0).
  - gate=0 in ATTACK/DECAY/SUSTAIN -> RELEASE.
- Otherwise per state:
  - IDLE: env holds 0.
  - ATTACK: if env + attack_rate >= ENV_MAX: env=ENV_MAX, -> DECAY; else env += attack_rate. attack_rate=0 holds.
  - DECAY: if env - decay_rate <= sustain_level (signed compare, no underflow): env=sustain_level, -> SUSTAIN; else env -= decay_rate.
  - SUSTAIN: env = sustain_level each tick (tracks live changes).
  - RELEASE: if env <= release_rate: env=0, -> IDLE; else env -= release_rate.
- Scaling: c = sample_in - 2^(DATA_BITS-1) as signed DATA_BITS; p = c * env (signed, DATA_BITS+ENV_BITS+1 bits); sample_out = (p >>> ENV_BITS) + 2^(DATA_BITS-1). Floor (arithmetic shift); result always in range, no clamp required.
- Scaling uses env value before that tick's update.

## Timing
- Reset: env_level=0, env_state=IDLE, busy=0, gate_prev=0, sample_out=2^(DATA_BITS-1), out_valid=0, pipeline valid cleared.
- Tick at cycle t: stage 1 registers c and pre-update env; env/state update visible at t+1; sample_out and out_valid=1 at t+2.
- Back-to-back ticks (every cycle) supported; out_valid then high continuously.
- rst mid-operation aborts in-flight samples: no out_valid after reset deassertion until a new tick propagates.
- Simultaneous rising gate and any level/rate transition: gate event wins.

## Configuration
- ADSR_EXP_RELEASE_EN defined: RELEASE step = (env >> release_rate[3:0]) + 1, clamp at 0, -> IDLE when env reaches 0; upper release_rate bits ignored.
- Undefined: linear release as above.

## Test plan
- Reset then ticks with gate=0, sample_in=4095 -> env_state=0, sample_out=2048 every out_valid, busy=0.
- attack_rate=16384, gate raised: gate tick -> ATTACK env 0; next ticks env 16384, 32768, 49152, 65535 with state -> DECAY on fourth.
- decay_rate=8192, sustain_level=40000 from 65535 -> 57343, 49151, 40959, 40000 SUSTAIN; change sustain_level to 30000 -> env 30000 next tick.
- env=65535, sample_in=4095 -> sample_out=4094 two cycles after tick; sample_in=0 -> 0; sample_in=2048 -> 2048.
- gate low at env=40000, release_rate=10000 -> RELEASE, then 30000, 20000, 10000, 0 IDLE; gate re-raised at env=20000 -> ATTACK continues from 20000.
- With ADSR_EXP_RELEASE_EN, release_rate=1, env=40000 -> 19999, 9999, 4999; rst asserted mid-release -> all outputs at reset values immediately.
